cpu_ctrl_seq: RTL and testbench
===============================

Name: cpu_ctrl_seq

Overview:
- Multi-cycle control sequencer for the 8-bit processor core: fetches a 16-bit instruction, decodes it, and drives the register-file, ALU and flag-register controls.
- Owns the program counter and resolves branches from the Z,N,V,C flags.
- Sits between instruction memory and the datapath; the regfile (R0..R7), ALU and flag register remain external.

Parameters:
- PC_W, 8, program counter / instruction address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request, held until acknowledged.
- imem_addr  output  PC_W  fetch address; equals pc.
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  16  instruction word.
- flags_in  input  4  current flags {Z,N,V,C}.
- rf_ra_addr  output  3  regfile read port A address (rs1).
- rf_rb_addr  output  3  regfile read port B address (rs2).
- rf_wa_addr  output  3  regfile write address (rd).
- rf_we  output  1  regfile write strobe, 1 cycle.
- wb_sel  output  1  write-back source: 0 = ALU result, 1 = imm.
- imm  output  8  instr[7:0].
- alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A.
- flags_we  output  1  flag register update strobe, 1 cycle.
- pc  output  PC_W  program counter.
- retire  output  1  1-cycle pulse when an instruction completes.
- halted  output  1  high in HALT state.

Behaviour:
- Instruction format: op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm8 = [7:0].
- Opcode map:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR.
  - 6 LDI: rd <= imm8.
  - 7 MOV: rd <= rs1 via PASS_A.
  - 8 CMP: SUB, flags only, no write.
  - 9 JMP imm8; A BZ; B BN; C BC; D BV.
  - E reserved, executes as NOP.
  - F HLT.
- Reset (rst low, asynchronous):
  - State = FETCH, pc = RESET_PC, instruction register = 0.
  - All strobes (imem_req, rf_we, flags_we, retire) = 0; halted = 0; alu_op = 0; wb_sel = 0.
- Reset release: imem_req rises on the first clk edge after rst deasserts.
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH; plus HALT.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On the edge where imem_ack = 1: latch imem_rdata into the instruction register and go to DECODE.
  - Otherwise stay in FETCH with req held; address stays stable.
- DECODE:
  - Drive rf_ra_addr, rf_rb_addr and rf_wa_addr from the instruction register.
  - These addresses are held stable through EXEC and WB.
- EXEC:
  - alu_op valid for all ALU ops, MOV and CMP.
  - flags_we = 1 for ADD, SUB, AND, OR, XOR and CMP.
  - No flag update for LDI, MOV, jumps or NOP.
  - Branch condition is sampled from flags_in in this cycle.
- WB:
  - rf_we = 1 for ADD, SUB, AND, OR, XOR, MOV (wb_sel = 0) and LDI (wb_sel = 1).
  - pc update at the end of WB:
    - JMP, or a conditional branch whose condition was true: pc <= imm8, zero-extended or truncated to PC_W.
    - Otherwise: pc <= pc + 1, wrapping modulo 2^PC_W (all ones -> 0).
  - retire = 1.
- HLT: goes EXEC -> HALT with pc unchanged and retire = 1 in the EXEC cycle. HALT is left only by reset.
- Throughput: 4 cycles per instruction with zero-wait ack; every wait cycle on imem_ack adds 1 cycle.
- Strobe exclusivity: rf_we and flags_we are never high in the same cycle.
- imem_ack outside FETCH is ignored.
- Reset mid-instruction: aborts immediately, no partial write; strobes drop asynchronously.

Optional Feature:
- Macro: CPU_CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state STEP_WAIT, entered after every retire.
  - On leaving reset, and after every retire, the sequencer waits in STEP_WAIT with imem_req = 0 until step = 1 is sampled, then enters FETCH.
  - Exactly one instruction is executed per step pulse; holding step high runs continuously.
- Undefined: no step port, no STEP_WAIT; the sequencer free-runs.

Test Plan:
- Reset then LDI R1,5 at pc 0 with ack tied high -> rf_we at cycle 4, wa = 1, wb_sel = 1, imm = 5, retire; pc = 1; imem_req rises on the first edge after reset release.
- R1 = 5, R2 = 5, CMP R1,R2 then BZ 0x20, ALU returns Z = 1 -> flags_we only in CMP EXEC, no rf_we; pc = 0x20 after BZ.
- BC 0x40 with flags_in = 0000 -> branch not taken; pc increments by 1.
- imem_ack delayed 3 cycles -> imem_req and imem_addr held stable; instruction takes 7 cycles; no strobes fire during the wait.
- pc = 0xFF executing NOP -> pc wraps to 0x00.
- HLT at pc 3 -> halted = 1, pc stays 3, no further imem_req; rst pulse low mid-EXEC of a later program -> rf_we and flags_we drop immediately, pc = RESET_PC.

Source files
------------

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq - multi-cycle control sequencer for the 8-bit processor core.
//
// Fetches a 16-bit instruction from instruction memory, decodes it and drives
// the external register file, ALU and flag-register controls. Owns the
// program counter and resolves branches from the {Z,N,V,C} flags.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   step         (CPU_CTRL_SINGLE_STEP_EN only) run one instruction per pulse
//   imem_req     fetch request, held until imem_ack
//   imem_addr    fetch address (= pc)
//   imem_ack     fetch data valid; ignored outside FETCH
//   imem_rdata   instruction word
//   flags_in     current flags {Z,N,V,C}
//   rf_ra_addr   regfile read port A (rs1)
//   rf_rb_addr   regfile read port B (rs2)
//   rf_wa_addr   regfile write address (rd)
//   rf_we        regfile write strobe (WB)
//   wb_sel       write-back source: 0 ALU result, 1 imm
//   imm          instr[7:0]
//   alu_op       0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A
//   flags_we     flag register update strobe (EXEC)
//   pc           program counter
//   retire       1-cycle pulse when an instruction completes
//   halted       high in HALT
//
// Build option: define CPU_CTRL_SINGLE_STEP_EN to add the step port and the
// STEP_WAIT state; without it the sequencer free-runs.
//
// State      | meaning
// -----------+-----------------------------------------------------------
// FETCH      | request instruction at pc, latch word on imem_ack
// DECODE     | register addresses presented from the instruction register
// EXEC       | ALU op + flag strobe, branch condition sampled; HLT retires
// WB         | regfile write strobe, pc update, retire
// HALT       | stopped until reset
// STEP_WAIT  | (single-step build) wait for step before the next fetch

module cpu_ctrl_seq #(
    parameter int unsigned      PC_W     = 8,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    input  logic [3:0]       flags_in,
    output logic [2:0]       rf_ra_addr,
    output logic [2:0]       rf_rb_addr,
    output logic [2:0]       rf_wa_addr,
    output logic             rf_we,
    output logic             wb_sel,
    output logic [7:0]       imm,
    output logic [2:0]       alu_op,
    output logic             flags_we,
    output logic [PC_W-1:0]  pc,
    output logic             retire,
    output logic             halted
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_MOV = 4'h7;
    localparam logic [3:0] OP_CMP = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_BZ  = 4'hA;
    localparam logic [3:0] OP_BN  = 4'hB;
    localparam logic [3:0] OP_BC  = 4'hC;
    localparam logic [3:0] OP_BV  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
`ifdef CPU_CTRL_SINGLE_STEP_EN
        , ST_STEP_WAIT = 3'd5
`endif
    } state_t;

`ifdef CPU_CTRL_SINGLE_STEP_EN
    localparam state_t ST_RESET   = ST_STEP_WAIT;
    localparam state_t ST_RETIRED = ST_STEP_WAIT;
`else
    localparam state_t ST_RESET   = ST_FETCH;
    localparam state_t ST_RETIRED = ST_FETCH;
`endif

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic             take_q, take_d;
    // Holds imem_req low for the first cycle out of reset so the request
    // rises on the first clock edge after release rather than with rst.
    logic             req_en_q;

    logic [3:0]       op;
    logic             is_alu;
    logic             writes_rf;
    logic             writes_flags;
    logic [2:0]       alu_code;
    logic             branch_cond;

    assign op           = ir_q[15:12];
    assign is_alu       = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                          (op == OP_OR)  || (op == OP_XOR);
    assign writes_rf    = is_alu || (op == OP_LDI) || (op == OP_MOV);
    assign writes_flags = is_alu || (op == OP_CMP);

    always_comb begin
        alu_code = ALU_ADD;
        case (op)
            OP_ADD:         alu_code = ALU_ADD;
            OP_SUB, OP_CMP: alu_code = ALU_SUB;
            OP_AND:         alu_code = ALU_AND;
            OP_OR:          alu_code = ALU_OR;
            OP_XOR:         alu_code = ALU_XOR;
            OP_MOV:         alu_code = ALU_PASS;
            default:        alu_code = ALU_ADD;
        endcase
    end

    // flags_in is {Z,N,V,C}
    always_comb begin
        branch_cond = 1'b0;
        case (op)
            OP_JMP:  branch_cond = 1'b1;
            OP_BZ:   branch_cond = flags_in[3];
            OP_BN:   branch_cond = flags_in[2];
            OP_BC:   branch_cond = flags_in[0];
            OP_BV:   branch_cond = flags_in[1];
            default: branch_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RESET;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            take_q   <= 1'b0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            take_q   <= take_d;
            req_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        take_d   = take_q;
        imem_req = 1'b0;
        rf_we    = 1'b0;
        flags_we = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        alu_op   = ALU_ADD;
        wb_sel   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = req_en_q;
                if (req_en_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_op  = alu_code;
                wb_sel  = (op == OP_LDI);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_op   = alu_code;
                wb_sel   = (op == OP_LDI);
                flags_we = writes_flags;
                take_d   = branch_cond;
                if (op == OP_HLT) begin
                    retire  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                // ALU op stays driven so the combinational ALU result is
                // still valid when the regfile captures it.
                alu_op  = alu_code;
                wb_sel  = (op == OP_LDI);
                rf_we   = writes_rf;
                retire  = 1'b1;
                pc_d    = take_q ? PC_W'(ir_q[7:0]) : pc_q + PC_W'(1);
                state_d = ST_RETIRED;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
`ifdef CPU_CTRL_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (step) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign rf_wa_addr = ir_q[11:9];
    assign rf_ra_addr = ir_q[8:6];
    assign rf_rb_addr = ir_q[5:3];
    assign imm        = ir_q[7:0];

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq. A memory responder supplies directed or
// random instructions, computes each instruction's expected effect from the
// ISA rules and queues it; a monitor collects strobes per instruction and
// compares at every retire.
module tb_cpu_ctrl_seq;

    localparam logic [7:0] RST_PC = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  flags_in;
    logic [2:0]  rf_ra_addr, rf_rb_addr, rf_wa_addr;
    logic        rf_we, wb_sel, flags_we, retire, halted;
    logic [7:0]  imm;
    logic [2:0]  alu_op;
    logic [7:0]  pc;

    cpu_ctrl_seq #(.PC_W(8), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .flags_in   (flags_in),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .rf_wa_addr (rf_wa_addr),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .imm        (imm),
        .alu_op     (alu_op),
        .flags_we   (flags_we),
        .pc         (pc),
        .retire     (retire),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  flags;
        int          waits;
    } stim_t;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
        bit          rf_we;
        bit          flags_we;
        bit          wb_sel;
        bit          hlt;
        logic [2:0]  wa;
        logic [2:0]  alu;
        logic [7:0]  imm;
        logic [7:0]  next_pc;
        int          cycles;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    int checks = 0;
    int failures = 0;
    int retire_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic stim_t mk(input logic [15:0] i, input logic [3:0] f, input int w);
        stim_t s;
        s.instr = i;
        s.flags = f;
        s.waits = w;
        return s;
    endfunction

    // Reference: what one instruction does, from the ISA description.
    function automatic exp_t model(input logic [7:0] at, input logic [15:0] ins,
                                   input logic [3:0] fl, input int waits);
        exp_t e;
        logic [3:0] op;
        bit take;
        op         = ins[15:12];
        e.pc       = at;
        e.instr    = ins;
        e.imm      = ins[7:0];
        e.wa       = ins[11:9];
        e.hlt      = (op == 4'hF);
        e.rf_we    = op inside {[4'h1:4'h7]};
        e.flags_we = op inside {[4'h1:4'h5], 4'h8};
        e.wb_sel   = (op == 4'h6);
        case (op)
            4'h1:       e.alu = 3'd0;
            4'h2, 4'h8: e.alu = 3'd1;
            4'h3:       e.alu = 3'd2;
            4'h4:       e.alu = 3'd3;
            4'h5:       e.alu = 3'd4;
            4'h7:       e.alu = 3'd5;
            default:    e.alu = 3'd0;
        endcase
        take = (op == 4'h9) ||
               (op == 4'hA && fl[3]) || (op == 4'hB && fl[2]) ||
               (op == 4'hC && fl[0]) || (op == 4'hD && fl[1]);
        if (e.hlt)     e.next_pc = at;
        else if (take) e.next_pc = ins[7:0];
        else           e.next_pc = at + 8'd1;
        e.cycles = (e.hlt ? 3 : 4) + waits;
        return e;
    endfunction

    // Instruction memory responder / stimulus generator.
    initial begin : responder
        logic [7:0]  model_pc;
        stim_t       s;
        exp_t        e;
        logic [15:0] w;
        model_pc   = RST_PC;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        flags_in   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_pc = RST_PC;
                imem_ack = 1'b0;
            end else if (imem_req) begin
                if (stim_q.size() > 0) begin
                    s = stim_q.pop_front();
                end else begin
                    w = 16'($urandom);
                    w[15:12] = 4'($urandom_range(0, 14));
                    s = mk(w, 4'($urandom), int'($urandom_range(0, 3)));
                end
                imem_ack = 1'b0;
                repeat (s.waits) @(negedge clk);
                if (rst) begin
                    e = model(model_pc, s.instr, s.flags, s.waits);
                    exp_q.push_back(e);
                    model_pc   = e.next_pc;
                    imem_rdata = s.instr;
                    flags_in   = s.flags;
                    imem_ack   = 1'b1;
                    @(negedge clk);
                    imem_ack   = 1'b0;
                    imem_rdata = 16'($urandom);
                end
            end else begin
                // stray acks while no fetch is pending must be ignored
                imem_ack   = ($urandom_range(0, 3) == 0);
                imem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        int   cyc, last_ret, n_rf, n_fl;
        bit   pend;
        exp_t pe, e;
        logic [2:0] c_wa, c_alu_fl, c_alu_wb;
        logic       c_wbsel;
        cyc = 0; last_ret = 0; n_rf = 0; n_fl = 0; pend = 0;
        c_wa = '0; c_alu_fl = '0; c_alu_wb = '0; c_wbsel = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                last_ret = cyc;
                n_rf = 0;
                n_fl = 0;
                pend = 0;
            end else begin
                if (pend) begin
                    chk("next_pc", pc, pe.next_pc);
                    chk("imem_addr", imem_addr, pe.next_pc);
                    if (pe.hlt) begin
                        chk("halted_after_hlt", halted, 1);
                        chk("req_after_hlt", imem_req, 0);
                    end
                    pend = 0;
                end
                if (rf_we || flags_we) chk("strobe_exclusive", rf_we && flags_we, 0);
                if (rf_we) begin
                    n_rf++;
                    c_wa = rf_wa_addr;
                    c_wbsel = wb_sel;
                    c_alu_wb = alu_op;
                end
                if (flags_we) begin
                    n_fl++;
                    c_alu_fl = alu_op;
                end
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("retire_pc", pc, e.pc);
                        chk("rf_we_count", n_rf, e.rf_we);
                        chk("flags_we_count", n_fl, e.flags_we);
                        chk("imm", imm, e.imm);
                        chk("ra_addr", rf_ra_addr, e.instr[8:6]);
                        chk("rb_addr", rf_rb_addr, e.instr[5:3]);
                        chk("cycles", cyc - last_ret, e.cycles);
                        chk("halted_at_retire", halted, 0);
                        if (e.rf_we) begin
                            chk("wa_addr", c_wa, e.wa);
                            chk("wb_sel", c_wbsel, e.wb_sel);
                            if (e.instr[15:12] == 4'h7) chk("mov_alu_op", c_alu_wb, 3'd5);
                        end
                        if (e.flags_we) chk("alu_op", c_alu_fl, e.alu);
                        pe = e;
                        pend = 1;
                    end
                    n_rf = 0;
                    n_fl = 0;
                    last_ret = cyc;
                    retire_cnt++;
                end
            end
        end
    end

    task automatic wait_retires(input int n, input int budget);
        int target;
        target = retire_cnt + n;
        for (int i = 0; i < budget && retire_cnt < target; i++) @(negedge clk);
        chk("retire_progress", retire_cnt >= target, 1);
    endtask

    initial begin : main
        rst = 1'b0;
        // directed program: LDI/CMP/BZ, untaken BC, slow fetch, pc wrap, HLT at 3
        stim_q.push_back(mk(16'h6205, 4'b0000, 0));   // 00 LDI R1,5
        stim_q.push_back(mk(16'h6405, 4'b0000, 0));   // 01 LDI R2,5
        stim_q.push_back(mk(16'h8050, 4'b1000, 0));   // 02 CMP R1,R2
        stim_q.push_back(mk(16'hA020, 4'b1000, 0));   // 03 BZ 0x20 (taken)
        stim_q.push_back(mk(16'hC040, 4'b0000, 1));   // 20 BC 0x40 (not taken)
        stim_q.push_back(mk(16'h0000, 4'b1111, 3));   // 21 NOP, 3 wait cycles
        stim_q.push_back(mk(16'h90FF, 4'b0000, 2));   // 22 JMP 0xFF
        stim_q.push_back(mk(16'h0000, 4'b0000, 0));   // FF NOP -> wraps to 00
        stim_q.push_back(mk(16'h9003, 4'b0000, 0));   // 00 JMP 3
        stim_q.push_back(mk(16'hF000, 4'b0000, 0));   // 03 HLT

        repeat (3) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_req", imem_req, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_flags_we", flags_we, 0);
        chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_wb_sel", wb_sel, 0);

        #1 rst = 1'b1;
        #1 chk("req_before_edge", imem_req, 0);
        @(posedge clk);
        #1 chk("req_first_edge", imem_req, 1);

        for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
        chk("halt_reached", halted, 1);
        repeat (8) begin
            @(negedge clk);
            chk("halt_stays", halted, 1);
            chk("halt_no_req", imem_req, 0);
            chk("halt_pc", pc, 8'h03);
        end

        // random program
        @(negedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        stim_q.delete();
        @(negedge clk);
        #1 rst = 1'b1;
        wait_retires(150, 3000);

        // reset in the middle of an EXEC cycle
        for (int i = 0; i < 200 && !flags_we; i++) @(negedge clk);
        chk("found_exec", flags_we, 1);
        #1 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_flags_we", flags_we, 0);
        chk("abort_rf_we", rf_we, 0);
        chk("abort_retire", retire, 0);
        chk("abort_pc", pc, RST_PC);
        chk("abort_req", imem_req, 0);
        chk("abort_alu_op", alu_op, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        wait_retires(30, 800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
